mem_arbiter: RTL

Two-port arbiter that shares the single-port synchronous block RAM (`memory`) between requester 0 (CPU load/store/fetch path) and requester 1 (I/O or loader path). It grants at most one access per clock, drives the RAM's address, write-data and write-enable inputs from the granted requester, and returns the one-cycle-latency read data to the requester that issued the read. Requester 0 has priority. An optional burst limit stops requester 1 from being starved.

---
 rtl/mem_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM; requester 0 has priority.
// Define MEM_ARB_BURST_LIMIT_EN to force requester 1 in after MAX_BURST contended requester-0 grants.
module mem_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_value,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_value
);

  logic              force_m1;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wdata;

`ifdef MEM_ARB_BURST_LIMIT_EN
  logic [3:0] burst_cnt;

  assign force_m1 = (burst_cnt == 4'(MAX_BURST));

  // Counts only contended requester-0 grants; any idle m1 cycle restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 burst_cnt <= 4'd0;
    else if (m1_gnt || !m1_req) burst_cnt <= 4'd0;
    else if (m0_gnt)            burst_cnt <= burst_cnt + 4'd1;
  end
`else
  logic unused_max_burst;

  assign force_m1         = 1'b0;
  assign unused_max_burst = ^4'(MAX_BURST);
`endif

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  assign m0_gnt = rst_n & m0_req & ~(m1_req & force_m1);
  assign m1_gnt = rst_n & m1_req & (~m0_req | force_m1);

  always_comb begin
    mem_address      = last_addr;
    mem_write_value  = last_wdata;
    mem_write_enable = 1'b0;
    if (m0_gnt) begin
      mem_address      = m0_addr;
      mem_write_value  = m0_wdata;
      mem_write_enable = m0_we;
    end else if (m1_gnt) begin
      mem_address      = m1_addr;
      mem_write_value  = m1_wdata;
      mem_write_enable = m1_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr  <= '0;
      last_wdata <= '0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
    end else begin
      last_addr  <= mem_address;
      last_wdata <= mem_write_value;
      m0_rvalid  <= m0_gnt & ~m0_we;
      m1_rvalid  <= m1_gnt & ~m1_we;
    end
  end

  // RAM data is broadcast; rvalid alone tells each port the word is theirs.
  assign m0_rdata = mem_read_value;
  assign m1_rdata = mem_read_value;

endmodule
